// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial sequence path.
// Used by the serializer and the detector bench.
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV   = 1;

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-period prescaler for the serializer.
// Pulses tick in the last clock of each held bit.
module seq_bit_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic load,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = en && (div_cnt == LAST);

   // Count clocks within a bit; restart on each new word.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// Streams back-to-back words with no idle gap.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DIV        = DEF_DIV,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_last
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted;
   logic [BW-1:0]    bit_cnt;
   logic             bit_tick;
   logic             xfer;
   logic             in_shift;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign in_shift   = (state == SHIFT);
   assign frame_last = ser_valid && (bit_cnt == LAST_BIT);
   assign din_ready  = !rst && (!in_shift || (frame_last && bit_tick));
   assign xfer       = din_valid && din_ready;
   assign shifted    = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_reg[WIDTH-1:1]};

   seq_bit_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (in_shift),
      .load (xfer),
      .tick (bit_tick)
   );

   // Word load, bit advance and end-of-word handling.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         ser_out   <= IDLE_LEVEL;
         ser_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (xfer) begin
                  state     <= SHIFT;
                  shift_reg <= din;
                  bit_cnt   <= '0;
                  ser_out   <= head(din);
                  ser_valid <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     if (xfer) begin
                        shift_reg <= din;
                        bit_cnt   <= '0;
                        ser_out   <= head(din);
                     end else begin
                        state     <= IDLE;
                        ser_out   <= IDLE_LEVEL;
                        ser_valid <= 1'b0;
                     end
                  end else begin
                     shift_reg <= shifted;
                     bit_cnt   <= bit_cnt + 1'b1;
                     ser_out   <= head(shifted);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
